serial_add_ctrl: RTL and testbench

Bit-serial sequencer that drives one external 1-bit full_adder instance (in1/in2/cin -> sum/cout) to add two WIDTH-bit operands, LSB first, one bit per clock.
- Latches operands on a start handshake.
- Feeds one bit pair per cycle to the adder and recirculates the adder's carry through a register.
- Assembles the sum and reports completion with a one-cycle done pulse.
- Lets the design reuse a single full_adder cell for wide additions where area matters more than latency.

---
 rtl/serial_add_ctrl_if.sv | 24 ++
 rtl/serial_add_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Request/result bus of the bit-serial adder sequencer.
// master: requester (drives start and operands); slave: the sequencer.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             result_cout;

    modport master (
        output start, op_a, op_b, op_cin,
        input  busy, done, result, result_cout
    );

    modport slave (
        input  start, op_a, op_b, op_cin,
        output busy, done, result, result_cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer: drives one external 1-bit full adder LSB first,
// recirculates its carry through a register and assembles a WIDTH-bit sum.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    serial_add_ctrl_if.slave bus,
    output logic             fa_in1,
    output logic             fa_in2,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_nx;
    logic [WIDTH-1:0] result_q;
    logic             result_cout_q;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             last;

    assign last   = (cnt == CW'(WIDTH - 1));
    // Shift-based form keeps the WIDTH=1 case free of reversed slices.
    assign sum_nx = (sum_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    assign bus.result      = result_q;
    assign bus.result_cout = result_cout_q;

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and per-state outputs; adder inputs are driven only in RUN
    always_comb begin
        state_nx = state;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        fa_in1   = 1'b0;
        fa_in2   = 1'b0;
        fa_cin   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                fa_in1   = a_sh[0];
                fa_in2   = b_sh[0];
                fa_cin   = carry_q;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand capture, serial shifting, carry recirculation and result latch
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            a_sh          <= '0;
            b_sh          <= '0;
            sum_sh        <= '0;
            carry_q       <= 1'b0;
            cnt           <= '0;
            result_q      <= '0;
            result_cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh    <= bus.op_a;
                        b_sh    <= bus.op_b;
                        carry_q <= bus.op_cin;
                        cnt     <= '0;
                        sum_sh  <= '0;
                    end
                end
                RUN: begin
                    sum_sh  <= sum_nx;
                    carry_q <= fa_cout;
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    cnt     <= cnt + CW'(1);
                    if (last) begin
                        result_q      <= sum_nx;
                        result_cout_q <= fa_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed scenarios at WIDTH=8 plus randomized
// back-to-back traffic at WIDTH=8, 1 and 16 checked through result scoreboards.
module tb_serial_add_ctrl;
    logic clk;
    logic rst_d;
    logic rst_r = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc_n  = 0;
    int   dones  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle count used to measure the done-to-done period
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- directed instance (WIDTH=8) ----------------
    serial_add_ctrl_if #(.WIDTH(8)) dbus ();
    logic d_in1, d_in2, d_cin, d_sum, d_cout;
    logic [8:0] dq[$];

    assign d_sum  = d_in1 ^ d_in2 ^ d_cin;
    assign d_cout = (d_in1 & d_in2) | (d_in1 & d_cin) | (d_in2 & d_cin);

    serial_add_ctrl #(.WIDTH(8)) dut_d (
        .sys_clk (clk),
        .sys_rst (rst_d),
        .bus     (dbus),
        .fa_in1  (d_in1),
        .fa_in2  (d_in2),
        .fa_cin  (d_cin),
        .fa_sum  (d_sum),
        .fa_cout (d_cout)
    );

    // Directed monitor: every done pulse must match the oldest expected sum
    always @(negedge clk) begin
        if (dbus.done) begin
            dones++;
            if (dq.size() == 0) chk("d_unexpected_done", 1, 0);
            else chk("d_result", {dbus.result_cout, dbus.result}, dq.pop_front());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit poke,
                        output int lat, output int busyc, output logic [7:0] cint);
        dbus.op_a   = a;
        dbus.op_b   = b;
        dbus.op_cin = c;
        dbus.start  = 1'b1;
        dq.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
        cyc();
        dbus.start = 1'b0;
        dbus.op_a  = ~a;
        dbus.op_b  = ~b;
        lat   = -1;
        busyc = 0;
        cint  = '0;
        for (int i = 0; i < 30; i++) begin
            if (!dbus.busy) break;
            busyc++;
            if (i < 8) cint[i[2:0]] = d_cin;
            if (dbus.done && lat < 0) lat = i;
            dbus.start = poke && (i == 3 || i == 8);
            if (dbus.start) dbus.op_a = 8'hAA;
            cyc();
        end
        dbus.start = 1'b0;
    endtask

    // ---------------- random instances (WIDTH = 8, 1, 16) ----------------
    for (genvar gi = 0; gi < 3; gi++) begin : g
        localparam int unsigned W = (gi == 0) ? 8 : ((gi == 1) ? 1 : 16);
        serial_add_ctrl_if #(.WIDTH(W)) bus ();
        logic in1, in2, cin, s, co;
        logic [W:0] q[$];
        int  last_done = -1;
        logic fin_b = 1'b0;

        assign s  = in1 ^ in2 ^ cin;
        assign co = (in1 & in2) | (in1 & cin) | (in2 & cin);

        serial_add_ctrl #(.WIDTH(W)) dut (
            .sys_clk (clk),
            .sys_rst (rst_r),
            .bus     (bus),
            .fa_in1  (in1),
            .fa_in2  (in2),
            .fa_cin  (cin),
            .fa_sum  (s),
            .fa_cout (co)
        );

        // Scoreboard monitor with back-to-back period check
        always @(negedge clk) begin
            if (!rst_r && bus.done) begin
                if (q.size() == 0) chk($sformatf("w%0d_unexpected_done", W), 1, 0);
                else chk($sformatf("w%0d_sum", W), {bus.result_cout, bus.result}, q.pop_front());
                if (last_done >= 0) chk($sformatf("w%0d_period", W), cyc_n - last_done, W + 2);
                last_done = cyc_n;
            end
        end

        initial begin
            logic [31:0] a, b;
            bus.start  = 1'b0;
            bus.op_a   = '0;
            bus.op_b   = '0;
            bus.op_cin = 1'b0;
            @(negedge rst_r);
            for (int k = 0; k < 200; k++) begin
                a = $urandom;
                b = $urandom;
                bus.op_a   = a[W-1:0];
                bus.op_b   = b[W-1:0];
                bus.op_cin = 1'($urandom_range(0, 1));
                q.push_back((W+1)'(bus.op_a) + (W+1)'(bus.op_b) + (W+1)'(bus.op_cin));
                bus.start = 1'b1;
                if (k == 0) begin
                    @(posedge clk);
                    #1;
                end else begin
                    repeat (W + 2) @(posedge clk);
                    #1;
                end
            end
            bus.start = 1'b0;
            repeat (W + 4) @(posedge clk);
            #1;
            chk($sformatf("w%0d_all_delivered", W), q.size(), 0);
            fin_b = 1'b1;
        end
    end

    // ---------------- directed sequence and summary ----------------
    initial begin
        int lat, busyc, d0;
        logic [7:0] cint;
        rst_d       = 1'b1;
        dbus.start  = 1'b0;
        dbus.op_a   = '0;
        dbus.op_b   = '0;
        dbus.op_cin = 1'b0;
        cyc();
        cyc();
        rst_d = 1'b0;
        rst_r = 1'b0;
        chk("rst_busy", dbus.busy, 0);
        chk("rst_done", dbus.done, 0);
        chk("rst_result", dbus.result, 0);
        chk("rst_cout", dbus.result_cout, 0);
        chk("rst_fa", {d_in1, d_in2, d_cin}, 0);

        run8(8'h5A, 8'h3C, 1'b0, 1'b0, lat, busyc, cint);
        chk("latency", lat, 8);
        chk("busy_cycles", busyc, 9);

        run8(8'hFF, 8'h01, 1'b0, 1'b0, lat, busyc, cint);
        chk("fa_cin_trace", cint, 8'hFE);

        run8(8'hFF, 8'h00, 1'b1, 1'b0, lat, busyc, cint);
        repeat (3) cyc();
        chk("hold_result", dbus.result, 8'h00);
        chk("hold_cout", dbus.result_cout, 1);
        run8(8'h00, 8'h00, 1'b0, 1'b0, lat, busyc, cint);

        d0 = dones;
        run8(8'h12, 8'h34, 1'b0, 1'b1, lat, busyc, cint);
        chk("ignore_start_busy", busyc, 9);
        chk("single_done", dones - d0, 1);
        cyc();
        chk("ignore_start_idle", dbus.busy, 0);

        // Abort 0x80+0x80 mid-run: nothing is expected from it
        dbus.op_a   = 8'h80;
        dbus.op_b   = 8'h80;
        dbus.op_cin = 1'b0;
        dbus.start  = 1'b1;
        cyc();
        dbus.start = 1'b0;
        repeat (4) cyc();
        rst_d = 1'b1;
        cyc();
        chk("abort_busy", dbus.busy, 0);
        chk("abort_done", dbus.done, 0);
        chk("abort_result", dbus.result, 0);
        chk("abort_cout", dbus.result_cout, 0);
        chk("abort_fa", {d_in1, d_in2, d_cin}, 0);
        rst_d = 1'b0;
        d0 = dones;
        repeat (12) cyc();
        chk("abort_no_done", dones - d0, 0);
        run8(8'h01, 8'h01, 1'b0, 1'b0, lat, busyc, cint);
        cyc();
        chk("d_all_delivered", dq.size(), 0);

        for (int t = 0; t < 60000; t++) begin
            if (g[0].fin_b && g[1].fin_b && g[2].fin_b) break;
            @(posedge clk);
        end
        chk("random_finished", {g[0].fin_b, g[1].fin_b, g[2].fin_b}, 3'b111);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
